// File: rtl/rc4_key_scheduler.sv
// RC4 key-scheduling pass over a single-port 256x8 S-box RAM.
// Each iteration reads S[i] and S[j], then swaps them with two writes.
module rc4_key_scheduler #(
  parameter int unsigned KEY_LEN = 3
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KEY_LEN*8-1:0] secret_key,
  input  logic [7:0]           s_q,
  output logic [7:0]           s_address,
  output logic [7:0]           s_data,
  output logic                 s_wren,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned KW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ_I,
    WAIT_I,
    READ_J,
    WAIT_J,
    WRITE_I,
    WRITE_J,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           i_q, i_d;
  logic [7:0]           j_q, j_d;
  logic [7:0]           si_q, si_d;
  logic [7:0]           sj_q, sj_d;
  logic [KW-1:0]        k_q, k_d;
  logic [KEY_LEN*8-1:0] key_q, key_d;
  logic [7:0]           key_byte;

  // k_q tracks i mod KEY_LEN; byte 0 sits in the most significant position.
  always_comb begin
    key_byte = '0;
    for (int unsigned n = 0; n < KEY_LEN; n++) begin
      if (k_q == KW'(n)) key_byte = key_q[(KEY_LEN-n)*8-1 -: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    sj_d      = sj_q;
    k_d       = k_q;
    key_d     = key_q;
    s_address = '0;
    s_data    = '0;
    s_wren    = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        busy = 1'b0;
        done = (state_q == DONE);
        if (start) begin
          key_d   = secret_key;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          state_d = READ_I;
        end
      end
      READ_I: begin
        s_address = i_q;
        state_d   = WAIT_I;
      end
      WAIT_I: begin
        s_address = i_q;
        si_d      = s_q;
        j_d       = j_q + s_q + key_byte;
        state_d   = READ_J;
      end
      READ_J: begin
        s_address = j_q;
        state_d   = WAIT_J;
      end
      WAIT_J: begin
        s_address = j_q;
        sj_d      = s_q;
        state_d   = WRITE_I;
      end
      WRITE_I: begin
        s_address = i_q;
        s_data    = sj_q;
        s_wren    = 1'b1;
        state_d   = WRITE_J;
      end
      WRITE_J: begin
        // When i==j the second write lands last and leaves si, the correct value.
        s_address = j_q;
        s_data    = si_q;
        s_wren    = 1'b1;
        if (i_q == 8'hFF) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 8'd1;
          k_d     = (k_q == KW'(KEY_LEN-1)) ? '0 : k_q + KW'(1);
          state_d = READ_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      k_q     <= '0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      k_q     <= k_d;
      key_q   <= key_d;
    end
  end

endmodule

// File: tb/tb_rc4_key_scheduler.sv
// Directed bench: two schedulers (KEY_LEN 3 and 1) on behavioural RAMs,
// checked against hand values and a software RC4 KSA model.
module tb_rc4_key_scheduler;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst, start3, start1, init3, init1, sel;
  logic [23:0] key3;
  logic [7:0]  key1;
  logic [7:0]  q3, addr3, data3, q1, addr1, data1;
  logic        wren3, busy3, done3, wren1, busy1, done1;
  logic [7:0]  mem3 [256];
  logic [7:0]  mem1 [256];
  logic [15:0] log3 [$];
  logic [15:0] log1 [$];
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_s [256];
  int          checks = 0;
  int          errors = 0;
  int          base;

  rc4_key_scheduler #(.KEY_LEN(3)) dut3 (
    .clock(clock), .rst(rst), .start(start3), .secret_key(key3), .s_q(q3),
    .s_address(addr3), .s_data(data3), .s_wren(wren3), .busy(busy3), .done(done3)
  );

  rc4_key_scheduler #(.KEY_LEN(1)) dut1 (
    .clock(clock), .rst(rst), .start(start1), .secret_key(key1), .s_q(q1),
    .s_address(addr1), .s_data(data1), .s_wren(wren1), .busy(busy1), .done(done1)
  );

  always @(posedge clock) begin
    if (init3) for (int a = 0; a < 256; a++) mem3[a] <= 8'(a);
    else if (wren3) mem3[addr3] <= data3;
    q3 <= mem3[addr3];
    if (init1) for (int a = 0; a < 256; a++) mem1[a] <= 8'(a);
    else if (wren1) mem1[addr1] <= data1;
    q1 <= mem1[addr1];
  end

  always @(negedge clock) begin
    if (wren3) log3.push_back({addr3, data3});
    if (wren1) log1.push_back({addr1, data1});
  end

  logic [7:0] m_addr, m_data;
  logic       m_wren, m_busy, m_done;
  assign m_addr = sel ? addr1 : addr3;
  assign m_data = sel ? data1 : data3;
  assign m_wren = sel ? wren1 : wren3;
  assign m_busy = sel ? busy1 : busy3;
  assign m_done = sel ? done1 : done3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ksa_model(input logic [255:0] key, input int len);
    logic [7:0] s [256];
    logic [7:0] j, t;
    exp_wr.delete();
    for (int i = 0; i < 256; i++) s[i] = 8'(i);
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      j = j + s[i] + key[(len-(i%len))*8-1 -: 8];
      exp_wr.push_back({8'(i), s[j]});
      exp_wr.push_back({j, s[i]});
      t = s[i]; s[i] = s[j]; s[j] = t;
    end
    for (int i = 0; i < 256; i++) exp_s[i] = s[i];
  endtask

  // mode 0: plain run; 1: restart attempt + key change at cycle 100; 2: reset in iteration 10 WRITE_I
  task automatic run(input bit s, input logic [255:0] key, input int len, input int mode,
                     input string tag);
    int cnt, bad, sz;
    logic prev_busy;
    sel = s;
    @(negedge clock);
    if (s) init1 = 1'b1; else init3 = 1'b1;
    @(negedge clock);
    init1 = 1'b0; init3 = 1'b0;
    base = s ? log1.size() : log3.size();
    if (s) begin key1 = key[7:0]; start1 = 1'b1; end
    else begin key3 = key[23:0]; start3 = 1'b1; end
    @(negedge clock);
    start1 = 1'b0; start3 = 1'b0;
    check({tag, "_busy_start"}, 32'(m_busy), 32'd1);
    cnt = 0;
    prev_busy = m_busy;
    while (!m_done && cnt < 3000) begin
      prev_busy = m_busy;
      @(negedge clock);
      cnt++;
      if (mode == 1 && cnt == 100) begin start3 = 1'b1; key3 = ~key3; end
      if (mode == 1 && cnt == 101) start3 = 1'b0;
      if (mode == 2 && cnt == 64) begin
        check({tag, "_wri_wren"}, 32'(m_wren), 32'd1);
        check({tag, "_wri_addr"}, 32'(m_addr), 32'd10);
        #1 rst = 1'b1;
        #1;
        check({tag, "_rst_addr"}, 32'(m_addr), 32'd0);
        check({tag, "_rst_data"}, 32'(m_data), 32'd0);
        check({tag, "_rst_wren"}, 32'(m_wren), 32'd0);
        check({tag, "_rst_busy"}, 32'(m_busy), 32'd0);
        check({tag, "_rst_done"}, 32'(m_done), 32'd0);
        @(negedge clock);
        rst = 1'b0;
        return;
      end
    end
    check({tag, "_latency"}, 32'(cnt), 32'd1536);
    check({tag, "_done"}, 32'(m_done), 32'd1);
    check({tag, "_busy_fall"}, {30'd0, prev_busy, m_busy}, 32'b10);
    ksa_model(key, len);
    sz = (s ? log1.size() : log3.size()) - base;
    check({tag, "_nwrites"}, 32'(sz), 32'd512);
    bad = 0;
    for (int n = 0; n < sz && n < 512; n++)
      if ((s ? log1[base+n] : log3[base+n]) !== exp_wr[n]) bad++;
    check({tag, "_wrseq_bad"}, 32'(bad), 32'd0);
    bad = 0;
    for (int a = 0; a < 256; a++)
      if ((s ? mem1[a] : mem3[a]) !== exp_s[a]) bad++;
    check({tag, "_sbox_bad"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int b1, bad;
    rst = 1'b1; start3 = 1'b0; start1 = 1'b0; init3 = 1'b0; init1 = 1'b0;
    key3 = '0; key1 = '0; sel = 1'b0;
    #1;
    check("rst_addr3", 32'(addr3), 32'd0);
    check("rst_data3", 32'(data3), 32'd0);
    check("rst_wren3", 32'(wren3), 32'd0);
    check("rst_busy3", 32'(busy3), 32'd0);
    check("rst_done3", 32'(done3), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_done1", 32'(done1), 32'd0);
    @(negedge clock);
    @(negedge clock);
    rst = 1'b0;

    run(1'b0, 256'h010203, 3, 0, "k010203");
    check("it0_wr_i", 32'(log3[base+0]), 32'h0001);
    check("it0_wr_j", 32'(log3[base+1]), 32'h0100);
    check("it1_wr_i", 32'(log3[base+2]), 32'h0103);
    check("it1_wr_j", 32'(log3[base+3]), 32'h0300);

    run(1'b0, 256'h000000, 3, 0, "k000000");
    check("ieqj_wr_i", 32'(log3[base+0]), 32'h0000);
    check("ieqj_wr_j", 32'(log3[base+1]), 32'h0000);
    check("ieqj_next", 32'(log3[base+2]), 32'h0101);

    run(1'b0, 256'h010203, 3, 1, "midrun_start");
    run(1'b0, 256'h010203, 3, 2, "midrun_rst");
    run(1'b0, 256'h0a0b0c, 3, 0, "after_rst");

    run(1'b1, 256'hff, 1, 0, "kff_run1");
    b1 = base;
    run(1'b1, 256'hff, 1, 0, "kff_run2");
    bad = 0;
    for (int n = 0; n < 512; n++) if (log1[b1+n] !== log1[base+n]) bad++;
    check("kff_rerun_same", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
